castlab_ws_array_ctrl: RTL and testbench

Sequencer for the weight-stationary PE array: per tile it clears and loads kernel weights, clears and streams input-feature vectors, then drains and counts partial-sum outputs. It sits between the top-level command interface and the array plus its weight/IF buffers. It drives the array's k_prefetch/if_start strobes and the buffer read handshakes, and reports done/error upstream.

---
 rtl/castlab_ws_ctrl_pkg.sv | 20 ++
 rtl/castlab_ctrl_counter.sv | 23 ++
 rtl/castlab_ws_array_ctrl.sv | 165 ++++++++++++++++
 tb/tb_castlab_ws_array_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/castlab_ws_ctrl_pkg.sv
// Shared state encoding and default sizing for the weight-stationary array sequencer.
package castlab_ws_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WCLR,
      S_WLOAD,
      S_ICLR,
      S_IFEED,
      S_DRAIN,
      S_DONE
   } ws_ctrl_state_e;

   localparam int ROWS_DEF          = 4;
   localparam int COLS_DEF          = 4;
   localparam int VEC_CNT_W_DEF     = 16;
   localparam int TILE_CNT_W_DEF    = 8;
   localparam int DRAIN_TIMEOUT_DEF = 256;

endpackage

// File: rtl/castlab_ctrl_counter.sv
// Clearable up-counter that holds once it reaches its terminal value; clear wins over increment.
module castlab_ctrl_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] term,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != term)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/castlab_ws_array_ctrl.sv
// Per-tile sequencer for the weight-stationary PE array: weight clear/load, IF clear/stream, psum drain.
// All strobes and requests are registered from the next-state decode.
module castlab_ws_array_ctrl
   import castlab_ws_ctrl_pkg::*;
#(
   parameter int ROWS          = ROWS_DEF,
   parameter int COLS          = COLS_DEF,
   parameter int VEC_CNT_W     = VEC_CNT_W_DEF,
   parameter int TILE_CNT_W    = TILE_CNT_W_DEF,
   parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [VEC_CNT_W-1:0]     cfg_num_vec,
   input  logic [TILE_CNT_W-1:0]    cfg_num_tiles,
   output logic                     busy,
   output logic                     done,
   output logic                     err,
   output logic                     k_prefetch,
   output logic                     w_valid,
   input  logic                     w_ready,
   output logic [$clog2(ROWS)-1:0]  w_row,
   output logic                     if_start,
   output logic                     if_valid,
   input  logic                     if_ready,
   output logic [VEC_CNT_W-1:0]     vec_idx,
   output logic [TILE_CNT_W-1:0]    tile_idx,
   input  logic                     psum_valid
);

   localparam int ROW_W = $clog2(ROWS);
   localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);

   // COLS only sizes the array datapath; it is checked here so a bad config fails at elaboration.
   if (ROWS < 2 || COLS < 1 || DRAIN_TIMEOUT < 1) begin : g_cfg_check
      $error("castlab_ws_array_ctrl: ROWS must be >= 2, COLS and DRAIN_TIMEOUT >= 1");
   end

   ws_ctrl_state_e          state, state_nx;
   logic [VEC_CNT_W-1:0]    num_vec_q;
   logic [TILE_CNT_W-1:0]   num_tiles_q;
   logic [VEC_CNT_W-1:0]    out_cnt;
   logic [TMR_W-1:0]        tmr;
   logic                    start_acc, err_set;
   logic                    w_last, v_last, t_last, tmo, drain_ok;

   assign w_last   = (w_row == ROW_W'(ROWS - 1));
   assign v_last   = (vec_idx == num_vec_q - VEC_CNT_W'(1));
   assign t_last   = (tile_idx == num_tiles_q - TILE_CNT_W'(1));
   assign tmo      = (tmr == TMR_W'(DRAIN_TIMEOUT - 1));
   // This cycle's psum beat counts toward completion, so the drain can finish on it.
   assign drain_ok = ({1'b0, out_cnt} + (VEC_CNT_W + 1)'(psum_valid)) >= {1'b0, num_vec_q};

   always_comb begin
      state_nx  = state;
      start_acc = 1'b0;
      err_set   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_nx  = (cfg_num_vec == '0 || cfg_num_tiles == '0) ? S_DONE : S_WCLR;
            end
         end
         S_WCLR:  state_nx = S_WLOAD;
         S_WLOAD: if (w_ready && w_last) state_nx = S_ICLR;
         S_ICLR:  state_nx = S_IFEED;
         S_IFEED: if (if_ready && v_last) state_nx = S_DRAIN;
         S_DRAIN: begin
            if (drain_ok) begin
               state_nx = t_last ? S_DONE : S_WCLR;
            end else if (tmo) begin
               err_set  = 1'b1;
               state_nx = S_DONE;
            end
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (abort) begin
         state_nx  = S_IDLE;
         start_acc = 1'b0;
         err_set   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         k_prefetch  <= 1'b0;
         w_valid     <= 1'b0;
         if_start    <= 1'b0;
         if_valid    <= 1'b0;
         num_vec_q   <= '0;
         num_tiles_q <= '0;
      end else begin
         state      <= state_nx;
         busy       <= state_nx inside {S_WCLR, S_WLOAD, S_ICLR, S_IFEED, S_DRAIN};
         done       <= (state_nx == S_DONE);
         k_prefetch <= (state_nx == S_WCLR);
         w_valid    <= (state_nx == S_WLOAD);
         if_start   <= (state_nx == S_ICLR);
         if_valid   <= (state_nx == S_IFEED);
         if (start_acc) begin
            num_vec_q   <= cfg_num_vec;
            num_tiles_q <= cfg_num_tiles;
            err         <= 1'b0;
         end else if (err_set) begin
            err <= 1'b1;
         end
      end
   end

   castlab_ctrl_counter #(.W(ROW_W)) u_w_row (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_nx == S_WCLR),
      .inc   (state == S_WLOAD && w_ready && !abort),
      .term  (ROW_W'(ROWS - 1)),
      .cnt   (w_row)
   );

   castlab_ctrl_counter #(.W(VEC_CNT_W)) u_vec_idx (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_nx == S_ICLR),
      .inc   (state == S_IFEED && if_ready && !abort),
      .term  (num_vec_q - VEC_CNT_W'(1)),
      .cnt   (vec_idx)
   );

   castlab_ctrl_counter #(.W(TILE_CNT_W)) u_tile_idx (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (start_acc),
      .inc   (state == S_DRAIN && state_nx == S_WCLR),
      .term  (num_tiles_q - TILE_CNT_W'(1)),
      .cnt   (tile_idx)
   );

   // Saturating: terminal value is all-ones so late extra beats cannot wrap it.
   castlab_ctrl_counter #(.W(VEC_CNT_W)) u_out_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_nx == S_ICLR),
      .inc   (psum_valid && (state == S_IFEED || state == S_DRAIN)),
      .term  ('1),
      .cnt   (out_cnt)
   );

   castlab_ctrl_counter #(.W(TMR_W)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_nx == S_ICLR),
      .inc   (state == S_DRAIN),
      .term  (TMR_W'(DRAIN_TIMEOUT - 1)),
      .cnt   (tmr)
   );

endmodule

// File: tb/tb_castlab_ws_array_ctrl.sv
// Job-level bench: table of jobs with a handshake scoreboard, plus reset and abort sequences.
module tb_castlab_ws_array_ctrl;

   localparam int ROWS = 4;

   logic        clk, rst_n, start, abort;
   logic [15:0] cfg_num_vec;
   logic [7:0]  cfg_num_tiles;
   logic        busy, done, err, k_prefetch, w_valid, w_ready, if_start, if_valid, if_ready;
   logic [1:0]  w_row;
   logic [15:0] vec_idx;
   logic [7:0]  tile_idx;
   logic        psum_valid;

   castlab_ws_array_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_num_vec(cfg_num_vec), .cfg_num_tiles(cfg_num_tiles),
      .busy(busy), .done(done), .err(err), .k_prefetch(k_prefetch),
      .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
      .if_start(if_start), .if_valid(if_valid), .if_ready(if_ready),
      .vec_idx(vec_idx), .tile_idx(tile_idx), .psum_valid(psum_valid)
   );

   typedef struct {
      int v; int t; bit rnd; bit psum; bit poke; bit exp_err; int exp_lat;
   } job_t;

   int n_chk = 0, n_pass = 0;
   int exp_w_q[$], exp_v_q[$], exp_t_q[$];
   int kp_cnt = 0, is_cnt = 0, done_cnt = 0, viol = 0;
   bit sb_en = 0, rnd_rdy = 0, psum_en = 0, hs_v_flag = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // Environment: ready generation and psum return two edges after each IF handshake.
   initial begin
      bit psum_d;
      psum_d = 1'b0;
      w_ready = 1'b0; if_ready = 1'b0; psum_valid = 1'b0;
      forever begin
         @(posedge clk); #1;
         psum_valid = psum_en & psum_d;
         psum_d     = hs_v_flag;
         w_ready    = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         if_ready   = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops scoreboard entries on each handshake / strobe.
   initial begin
      forever begin
         @(negedge clk);
         hs_v_flag = if_valid && if_ready;
         if (k_prefetch && if_start) viol++;
         if (w_valid && if_valid) viol++;
         if (done) done_cnt++;
         if (if_start) is_cnt++;
         if (k_prefetch) begin
            kp_cnt++;
            if (sb_en) begin
               chk("tile_expected", exp_t_q.size() > 0, 1);
               if (exp_t_q.size() > 0) chk("tile_idx", tile_idx, exp_t_q.pop_front());
            end
         end
         if (sb_en && w_valid && w_ready) begin
            chk("w_beat_expected", exp_w_q.size() > 0, 1);
            if (exp_w_q.size() > 0) chk("w_row", w_row, exp_w_q.pop_front());
         end
         if (sb_en && if_valid && if_ready) begin
            chk("if_beat_expected", exp_v_q.size() > 0, 1);
            if (exp_v_q.size() > 0) chk("vec_idx", vec_idx, exp_v_q.pop_front());
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic run_job(input job_t r);
      int run_t, k;
      run_t = (r.v == 0 || r.t == 0) ? 0 : (r.exp_err ? 1 : r.t);
      for (int tl = 0; tl < run_t; tl++) begin
         exp_t_q.push_back(tl);
         for (int rw = 0; rw < ROWS; rw++) exp_w_q.push_back(rw);
         for (int vv = 0; vv < r.v; vv++) exp_v_q.push_back(vv);
      end
      kp_cnt = 0; is_cnt = 0; done_cnt = 0;
      rnd_rdy = r.rnd; psum_en = r.psum; sb_en = 1;
      cfg_num_vec = 16'(r.v); cfg_num_tiles = 8'(r.t); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      while (k < 3000) begin
         @(negedge clk);
         if (done) break;
         if (k == 1 && run_t > 0) chk("busy_running", busy, 1);
         if (r.poke) begin
            start = (k == 4);
            if (k == 4) begin
               cfg_num_vec = 16'd9; cfg_num_tiles = 8'd5;
            end
         end
         k++;
      end
      start = 1'b0;
      chk("done_seen", done, 1);
      if (r.exp_lat >= 0) chk("latency", k, r.exp_lat);
      chk("err_at_done", err, r.exp_err);
      chk("busy_at_done", busy, 0);
      repeat (3) @(negedge clk);
      chk("done_pulses", done_cnt, 1);
      chk("k_prefetch_cnt", kp_cnt, run_t);
      chk("if_start_cnt", is_cnt, run_t);
      chk("sb_leftover", exp_w_q.size() + exp_v_q.size() + exp_t_q.size(), 0);
      exp_w_q.delete(); exp_v_q.delete(); exp_t_q.delete();
      sb_en = 0;
   endtask

   initial begin
      job_t tbl[8];
      int n;
      tbl[0] = '{v:3, t:1, rnd:0, psum:1, poke:0, exp_err:0, exp_lat:11};
      tbl[1] = '{v:2, t:3, rnd:0, psum:1, poke:0, exp_err:0, exp_lat:30};
      tbl[2] = '{v:5, t:2, rnd:1, psum:1, poke:0, exp_err:0, exp_lat:-1};
      tbl[3] = '{v:2, t:2, rnd:0, psum:0, poke:0, exp_err:1, exp_lat:264};
      tbl[4] = '{v:3, t:1, rnd:0, psum:1, poke:1, exp_err:0, exp_lat:11};
      tbl[5] = '{v:0, t:2, rnd:0, psum:1, poke:0, exp_err:0, exp_lat:0};
      tbl[6] = '{v:4, t:0, rnd:0, psum:1, poke:0, exp_err:0, exp_lat:0};
      tbl[7] = '{v:1, t:2, rnd:1, psum:1, poke:0, exp_err:0, exp_lat:-1};

      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_num_vec = '0; cfg_num_tiles = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_strobes", {k_prefetch, if_start, w_valid, if_valid}, 0);
      chk("rst_w_row", w_row, 0);
      chk("rst_vec_idx", vec_idx, 0);
      chk("rst_tile_idx", tile_idx, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", busy, 0);

      for (int i = 0; i < 8; i++) run_job(tbl[i]);

      // Abort in the middle of the weight load.
      sb_en = 0; rnd_rdy = 0; psum_en = 1; done_cnt = 0;
      cfg_num_vec = 16'd2; cfg_num_tiles = 8'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (!(w_valid && w_row == 2'd2) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("abort_reached_wload", w_valid, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_strobes", {k_prefetch, if_start, w_valid, if_valid, done}, 0);
      repeat (10) @(negedge clk);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_err_kept", err, 0);

      run_job('{v:3, t:1, rnd:0, psum:1, poke:0, exp_err:0, exp_lat:11});
      chk("strobe_overlap", viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
